// File: rtl/uart_shift_register.sv
// Parallel-load / serial-shift register with a modulo-WIDTH shift counter.
// Used as the UART TX serialiser and the RX deserialiser.
module uart_shift_register #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b1,
    localparam int unsigned CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic [CW-1:0]    count,
    output logic             done
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;

    // Next state: load beats shift, shift beats hold; done only on the WIDTH-th shift.
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            q_d     = d;
            count_d = '0;
        end else if (shift_en) begin
            if (LSB_FIRST) begin
                q_d = {serial_in, q_q[WIDTH-1:1]};
            end else begin
                q_d = {q_q[WIDTH-2:0], serial_in};
            end
            done_d  = (count_q == LAST_COUNT);
            count_d = done_d ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= {WIDTH{IDLE_LEVEL}};
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign q          = q_q;
    assign count      = count_q;
    assign done       = done_q;
    // Outgoing bit depends on the register only, never on the inputs.
    assign serial_out = LSB_FIRST ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_uart_shift_register.sv
// Bench for uart_shift_register: LSB-first and MSB-first WIDTH=8 instances plus a WIDTH=4 wrap instance.
module tb_uart_shift_register;

    typedef struct {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       dn;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       a_load = 1'b0, a_sh = 1'b0, a_si = 1'b0, a_so, a_done;
    logic [7:0] a_d = 8'h00, a_q;
    logic [2:0] a_cnt;
    logic       b_load = 1'b0, b_sh = 1'b0, b_si = 1'b0, b_so, b_done;
    logic [7:0] b_d = 8'h00, b_q;
    logic [2:0] b_cnt;
    logic       c_load = 1'b0, c_sh = 1'b0, c_si = 1'b0, c_so, c_done;
    logic [3:0] c_d = 4'h0, c_q;
    logic [1:0] c_cnt;

    uart_shift_register #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .load(a_load), .d(a_d), .shift_en(a_sh),
        .serial_in(a_si), .q(a_q), .serial_out(a_so), .count(a_cnt), .done(a_done));

    uart_shift_register #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load(b_load), .d(b_d), .shift_en(b_sh),
        .serial_in(b_si), .q(b_q), .serial_out(b_so), .count(b_cnt), .done(b_done));

    uart_shift_register #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .reset(reset), .load(c_load), .d(c_d), .shift_en(c_sh),
        .serial_in(c_si), .q(c_q), .serial_out(c_so), .count(c_cnt), .done(c_done));

    int   errors = 0;
    int   checks = 0;
    int   hits_a = 0;
    int   hits_b = 0;
    exp_t m_a, m_b;
    exp_t sb_a[$];
    exp_t sb_b[$];

    function automatic exp_t nxt(input exp_t s, input bit lsb, input logic ld,
                                 input logic [7:0] dd, input logic sh, input logic si);
        exp_t r;
        r    = s;
        r.dn = 1'b0;
        if (ld) begin
            r.q   = dd;
            r.cnt = 3'd0;
        end else if (sh) begin
            r.q   = lsb ? {si, s.q[7:1]} : {s.q[6:0], si};
            r.dn  = (s.cnt == 3'd7);
            r.cnt = s.cnt + 3'd1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_a.q = 8'hFF; m_a.cnt = 3'd0; m_a.dn = 1'b0;
        m_b.q = 8'hFF; m_b.cnt = 3'd0; m_b.dn = 1'b0;
    endtask

    // One clock of instance A: predict, push, clock, pop and compare.
    task automatic cyc_a(input logic ld, input logic [7:0] dd, input logic sh, input logic si);
        exp_t e;
        a_load = ld; a_d = dd; a_sh = sh; a_si = si;
        m_a = nxt(m_a, 1'b1, ld, dd, sh, si);
        sb_a.push_back(m_a);
        @(posedge clk); #1;
        a_load = 1'b0; a_sh = 1'b0; a_si = 1'b0;
        e = sb_a.pop_front();
        checks++;
        if ({a_q, a_cnt, a_done} !== {e.q, e.cnt, e.dn}) begin
            errors++;
            $display("FAIL sb_a: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b",
                     a_q, a_cnt, a_done, e.q, e.cnt, e.dn);
        end
        if (a_done === 1'b1) hits_a++;
    endtask

    task automatic cyc_b(input logic ld, input logic [7:0] dd, input logic sh, input logic si);
        exp_t e;
        b_load = ld; b_d = dd; b_sh = sh; b_si = si;
        m_b = nxt(m_b, 1'b0, ld, dd, sh, si);
        sb_b.push_back(m_b);
        @(posedge clk); #1;
        b_load = 1'b0; b_sh = 1'b0; b_si = 1'b0;
        e = sb_b.pop_front();
        checks++;
        if ({b_q, b_cnt, b_done} !== {e.q, e.cnt, e.dn}) begin
            errors++;
            $display("FAIL sb_b: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b",
                     b_q, b_cnt, b_done, e.q, e.cnt, e.dn);
        end
        if (b_done === 1'b1) hits_b++;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_q, a_so, a_cnt, a_done, b_q, b_so, b_cnt, b_done, c_q, c_so, c_cnt, c_done} !==
            {8'hFF, 1'b1, 3'd0, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 4'hF, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_init: a=%h/%b/%0d/%b b=%h/%b/%0d/%b c=%h/%b/%0d/%b, expected FF/1/0/0 FF/1/0/0 F/1/0/0",
                     a_q, a_so, a_cnt, a_done, b_q, b_so, b_cnt, b_done, c_q, c_so, c_cnt, c_done);
        end
        reset = 1'b1;
        cyc_a(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc_a(1'b1, 8'h3C, 1'b0, 1'b0);
        // Assert reset between edges; outputs must change before the next edge.
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({a_q, a_so, a_cnt, a_done} !== {8'hFF, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: q=%h so=%b cnt=%0d done=%b, expected q=ff so=1 cnt=0 done=0",
                     a_q, a_so, a_cnt, a_done);
        end
        reset = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_tx();
        logic [7:0] seq;
        seq = 8'hA5;
        hits_a = 0;
        cyc_a(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_so !== seq[i]) begin
                errors++;
                $display("FAIL tx_serial_out[%0d]: got %b expected %b", i, a_so, seq[i]);
            end
            cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if ({a_q, a_cnt, a_done} !== {8'h00, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL tx_final: q=%h cnt=%0d done=%b, expected q=00 cnt=0 done=1", a_q, a_cnt, a_done);
        end
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (hits_a !== 1) begin
            errors++;
            $display("FAIL tx_done_pulses: got %0d expected 1", hits_a);
        end
    endtask

    task automatic test_rx();
        logic [7:0] bits;
        bits = 8'b0101_0011;
        hits_a = 0;
        cyc_a(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc_a(1'b0, 8'h00, 1'b1, bits[i]);
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (a_q !== 8'h53 || hits_a !== 1) begin
            errors++;
            $display("FAIL rx_capture: q=%h pulses=%0d, expected q=53 pulses=1", a_q, hits_a);
        end
    endtask

    task automatic test_collision_gaps();
        hits_a = 0;
        cyc_a(1'b1, 8'h5A, 1'b1, 1'b1);
        checks++;
        if ({a_q, a_cnt} !== {8'h5A, 3'd0}) begin
            errors++;
            $display("FAIL load_beats_shift: q=%h cnt=%0d, expected q=5a cnt=0", a_q, a_cnt);
        end
        for (int i = 0; i < 3; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (a_cnt !== 3'd3 || a_done !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d]: cnt=%0d done=%b, expected cnt=3 done=0", i, a_cnt, a_done);
            end
        end
        for (int i = 0; i < 5; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_done !== 1'b1 || hits_a !== 1) begin
            errors++;
            $display("FAIL gap_done: done=%b pulses=%0d, expected done=1 pulses=1", a_done, hits_a);
        end
        cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b1111_0000;
        hits_b = 0;
        cyc_b(1'b1, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (b_so !== seq[i]) begin
                errors++;
                $display("FAIL msb_serial_out[%0d]: got %b expected %b", i, b_so, seq[i]);
            end
            cyc_b(1'b0, 8'h00, 1'b1, 1'b1);
        end
        cyc_b(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (b_q !== 8'hFF || hits_b !== 1) begin
            errors++;
            $display("FAIL msb_final: q=%h pulses=%0d, expected q=ff pulses=1", b_q, hits_b);
        end
    endtask

    task automatic test_reset_mid_run();
        hits_a = 0;
        cyc_a(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b1, 1'b0);
        #2 reset = 1'b0;
        a_sh = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({a_q, a_cnt, a_done} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset: q=%h cnt=%0d done=%b, expected q=ff cnt=0 done=0", a_q, a_cnt, a_done);
        end
        // Reset held across an edge with shift_en high must still dominate.
        @(posedge clk); #1;
        checks++;
        if ({a_q, a_cnt, a_done} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: q=%h cnt=%0d done=%b, expected q=ff cnt=0 done=0", a_q, a_cnt, a_done);
        end
        a_sh = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (hits_a !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d pulses expected 0", hits_a);
        end
    endtask

    task automatic test_wrap_w4();
        logic [7:0] seen;
        seen = 8'h00;
        c_load = 1'b1; c_d = 4'h0;
        @(posedge clk); #1;
        c_load = 1'b0;
        checks++;
        if ({c_q, c_cnt, c_done} !== {4'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL w4_load: q=%h cnt=%0d done=%b, expected q=0 cnt=0 done=0", c_q, c_cnt, c_done);
        end
        c_sh = 1'b1; c_si = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen[i] = c_done;
        end
        c_sh = 1'b0; c_si = 1'b0;
        checks++;
        if (seen !== 8'b1000_1000) begin
            errors++;
            $display("FAIL w4_wrap_done: pattern=%b expected 10001000", seen);
        end
        checks++;
        if ({c_q, c_so, c_cnt} !== {4'hF, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL w4_final: q=%h so=%b cnt=%0d, expected q=f so=1 cnt=0", c_q, c_so, c_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_collision_gaps();
        test_msb_first();
        test_reset_mid_run();
        test_wrap_w4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
